// File: rtl/equation_checker_if.sv
// Operand-entry / result bus of the equation checker.
// master: the player-facing side (button, switches, timer); slave: the engine.
interface equation_checker_if #(
  parameter int WIDTH       = 8,
  parameter int TIMER_WIDTH = 7
);
  logic                   Go;
  logic                   startEq;
  logic [1:0]             mode;
  logic [TIMER_WIDTH-1:0] OngoingTimer;
  logic [WIDTH-1:0]       DataIn;
  logic                   busy;
  logic                   done;
  logic                   correct;
  logic                   div_err;
  logic [WIDTH-1:0]       result;
  logic [3:0]             attempts;

  modport master (
    output Go, startEq, mode, OngoingTimer, DataIn,
    input  busy, done, correct, div_err, result, attempts
  );

  modport slave (
    input  Go, startEq, mode, OngoingTimer, DataIn,
    output busy, done, correct, div_err, result, attempts
  );
endinterface

// File: rtl/equation_checker.sv
// Equation checker: captures a target from the running timer, collects three
// operands X/Y/Z (one per Go press), evaluates the selected equation on one
// shared ALU over four CALC cycles and compares against the target.
// Optional retry feature: define EQ_RETRY_EN to let a Go press after a wrong
// answer restart operand entry while keeping target and mode.
module equation_checker #(
  parameter int WIDTH       = 8,
  parameter int TIMER_WIDTH = 7
) (
  input logic               Clock,
  input logic               Reset,
  equation_checker_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, LOAD_X, WAIT_X, LOAD_Y, WAIT_Y, LOAD_Z, WAIT_Z,
    CALC0, CALC1, CALC2, CALC3, COMPARE, RESULT, CLEAR
  } state_t;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} alu_op_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] x_reg, y_reg, z_reg, target_reg, result_reg;
  logic [1:0]       mode_reg;
  logic             correct_reg, div_err_reg;
  logic             clear_now;

  alu_op_t          alu_op;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  logic             alu_dz, we_x, we_y, we_r;

`ifdef EQ_RETRY_EN
  logic [3:0]       attempts_reg;
`endif

  // State register; reset wins over everything.
  always_ff @(posedge Clock) begin
    if (Reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic: operand handshake, fixed CALC sequence, abort to CLEAR.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.startEq) state_next = LOAD_X;
      LOAD_X:  if (bus.Go)      state_next = WAIT_X;
      WAIT_X:  if (!bus.Go)     state_next = LOAD_Y;
      LOAD_Y:  if (bus.Go)      state_next = WAIT_Y;
      WAIT_Y:  if (!bus.Go)     state_next = LOAD_Z;
      LOAD_Z:  if (bus.Go)      state_next = WAIT_Z;
      WAIT_Z:  if (!bus.Go)     state_next = CALC0;
      CALC0:   state_next = CALC1;
      CALC1:   state_next = CALC2;
      CALC2:   state_next = CALC3;
      CALC3:   state_next = COMPARE;
      COMPARE: state_next = RESULT;
      RESULT: begin
        if (!bus.startEq) state_next = CLEAR;
`ifdef EQ_RETRY_EN
        else if (bus.Go && !correct_reg) state_next = LOAD_X;
`endif
      end
      CLEAR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Dropping startEq mid-round abandons it; done never asserts.
    if (!bus.startEq && state_reg != IDLE && state_reg != RESULT && state_reg != CLEAR)
      state_next = CLEAR;
  end

  assign clear_now = (state_next == CLEAR) || (state_reg == CLEAR);

  // ALU schedule: which operation runs in each CALC cycle and where it lands.
  always_comb begin
    alu_op = OP_ADD;
    alu_a  = x_reg;
    alu_b  = y_reg;
    we_x   = 1'b0;
    we_y   = 1'b0;
    we_r   = 1'b0;
    case (state_reg)
      CALC0: begin
        we_x = 1'b1;
        case (mode_reg)
          2'd0:    begin alu_op = OP_DIV; alu_b = z_reg; end  // X/Z
          2'd1:    alu_op = OP_MUL;                           // X*Y
          2'd2:    alu_op = OP_ADD;                           // X+Y
          default: begin alu_op = OP_MUL; alu_b = z_reg; end  // X*Z
        endcase
      end
      CALC1: if (mode_reg == 2'd0) begin
        we_y = 1'b1; alu_op = OP_DIV; alu_a = y_reg; alu_b = z_reg;   // Y/Z
      end
      CALC2: if (mode_reg == 2'd0) begin
        we_x = 1'b1; alu_op = OP_MUL; alu_b = x_reg;                  // (X/Z)^2
      end
      CALC3: begin
        we_r = 1'b1;
        case (mode_reg)
          2'd0:    alu_op = OP_ADD;
          2'd1:    begin alu_op = OP_ADD; alu_b = z_reg; end
          2'd2:    begin alu_op = OP_DIV; alu_b = z_reg; end
          default: alu_op = OP_SUB;
        endcase
      end
      default: ;
    endcase
  end

  // Shared unsigned ALU; divide by zero yields all-ones and flags it.
  always_comb begin
    alu_y  = '0;
    alu_dz = 1'b0;
    case (alu_op)
      OP_ADD: alu_y = alu_a + alu_b;
      OP_SUB: alu_y = alu_a - alu_b;
      OP_MUL: alu_y = alu_a * alu_b;
      OP_DIV: begin
        if (alu_b == '0) begin
          alu_y  = '1;
          alu_dz = 1'b1;
        end else begin
          alu_y  = alu_a / alu_b;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers: capture, ALU write-back, compare, clear and retry.
  always_ff @(posedge Clock) begin
    if (Reset || clear_now) begin
      x_reg       <= '0;
      y_reg       <= '0;
      z_reg       <= '0;
      target_reg  <= '0;
      result_reg  <= '0;
      mode_reg    <= 2'd0;
      correct_reg <= 1'b0;
      div_err_reg <= 1'b0;
`ifdef EQ_RETRY_EN
      attempts_reg <= 4'd0;
`endif
    end else begin
      case (state_reg)
        IDLE: if (bus.startEq) begin
          target_reg <= WIDTH'(bus.OngoingTimer);
          mode_reg   <= bus.mode;
        end
        LOAD_X: if (bus.Go) x_reg <= bus.DataIn;
        LOAD_Y: if (bus.Go) y_reg <= bus.DataIn;
        LOAD_Z: if (bus.Go) z_reg <= bus.DataIn;
        CALC0, CALC1, CALC2, CALC3: begin
          if (we_x)   x_reg       <= alu_y;
          if (we_y)   y_reg       <= alu_y;
          if (we_r)   result_reg  <= alu_y;
          if (alu_dz) div_err_reg <= 1'b1;
        end
        COMPARE: correct_reg <= (result_reg == target_reg) && !div_err_reg;
`ifdef EQ_RETRY_EN
        RESULT: if (state_next == LOAD_X) begin
          x_reg       <= '0;
          y_reg       <= '0;
          z_reg       <= '0;
          result_reg  <= '0;
          div_err_reg <= 1'b0;
          correct_reg <= 1'b0;
          if (attempts_reg != 4'd15) attempts_reg <= attempts_reg + 4'd1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state_reg != IDLE) && (state_reg != RESULT);
  assign bus.done    = (state_reg == RESULT);
  assign bus.correct = correct_reg;
  assign bus.div_err = div_err_reg;
  assign bus.result  = result_reg;
`ifdef EQ_RETRY_EN
  assign bus.attempts = attempts_reg;
`else
  assign bus.attempts = 4'd0;
`endif

endmodule

// File: tb/tb_equation_checker.sv
// Scoreboard bench for equation_checker: stimulus pushes the expected outcome
// of each round; a negedge monitor pops and compares when done rises.
module tb_equation_checker;
  localparam int WIDTH       = 8;
  localparam int TIMER_WIDTH = 7;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  equation_checker_if #(.WIDTH(WIDTH), .TIMER_WIDTH(TIMER_WIDTH)) bus ();

  equation_checker #(.WIDTH(WIDTH), .TIMER_WIDTH(TIMER_WIDTH)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [7:0] result;
    logic       correct;
    logic       div_err;
    logic [3:0] attempts;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_round = 0;
  logic done_prev = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Reference: the equations evaluated with plain integer arithmetic mod 256.
  function automatic exp_t model(input int m, input int t, input int x, input int y,
                                 input int z, input int att);
    exp_t e;
    int   r, q1, q2;
    bit   dz;
    dz = (z == 0) && (m == 0 || m == 2);
    case (m)
      0: begin
        q1 = (z == 0) ? 255 : x / z;
        q2 = (z == 0) ? 255 : y / z;
        r  = (q1 * q1 + q2) % 256;
      end
      1: r = (x * y + z) % 256;
      2: r = (z == 0) ? 255 : ((x + y) % 256) / z;
      default: r = ((x * z - y) % 256 + 256) % 256;
    endcase
    e.result   = 8'(r);
    e.correct  = (r == t) && !dz;
    e.div_err  = dz;
    e.attempts = 4'(att);
    return e;
  endfunction

  // Monitor: one comparison set per completed round, plus correct==0 outside RESULT.
  always @(negedge Clock) begin
    if (Reset) begin
      done_prev = 1'b0;
    end else begin
      if (bus.done && !done_prev) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          n_round++;
          $display("round %0d: result=%0d correct=%0d div_err=%0d attempts=%0d (expected %0d/%0d/%0d/%0d)",
                   n_round, bus.result, bus.correct, bus.div_err, bus.attempts,
                   cur.result, cur.correct, cur.div_err, cur.attempts);
          check("result", int'(bus.result), int'(cur.result));
          check("correct", int'(bus.correct), int'(cur.correct));
          check("div_err", int'(bus.div_err), int'(cur.div_err));
          check("attempts", int'(bus.attempts), int'(cur.attempts));
          check("busy_in_result", int'(bus.busy), 0);
        end
      end
      if (!bus.done) check("correct_outside_result", int'(bus.correct), 0);
      done_prev = bus.done;
    end
  end

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  task automatic start_round(input int m, input int t);
    @(negedge Clock);
    bus.startEq      = 1'b1;
    bus.mode         = 2'(m);
    bus.OngoingTimer = 7'(t);
  endtask

  // One Go press; hold>0 keeps Go high for extra cycles while DataIn wanders.
  task automatic press(input logic [7:0] v, input int hold);
    @(negedge Clock);
    bus.DataIn = v;
    bus.Go     = 1'b1;
    repeat (hold) begin
      @(negedge Clock);
      bus.DataIn = 8'($urandom);
    end
    @(negedge Clock);
    bus.Go = 1'b0;
  endtask

  task automatic eval(input int m, input int t, input int x, input int y, input int z,
                      input int att, input int hold);
    int n;
    exp_q.push_back(model(m, t, x, y, z, att));
    press(8'(x), hold);
    press(8'(y), 0);
    press(8'(z), 0);
    @(posedge Clock);  // edge that leaves WAIT_Z
    n = 0;
    while (n < 12) begin
      @(posedge Clock);
      #1;
      n++;
      if (bus.done) break;
    end
    check("done_latency", n, 5);
  endtask

  task automatic end_round();
    @(negedge Clock);
    bus.startEq = 1'b0;
    @(posedge Clock);
    @(posedge Clock);
    #1;
    check("idle_busy", int'(bus.busy), 0);
    check("idle_attempts", int'(bus.attempts), 0);
  endtask

  task automatic go_in_result(input int att);
    @(negedge Clock);
    bus.Go = 1'b1;
    @(posedge Clock);
    #1;
    check("go_ignored_done", int'(bus.done), 1);
    check("go_ignored_attempts", int'(bus.attempts), att);
    @(negedge Clock);
    bus.Go = 1'b0;
  endtask

`ifdef EQ_RETRY_EN
  task automatic retry_press(input int att);
    @(negedge Clock);
    bus.Go = 1'b1;
    @(posedge Clock);
    #1;
    check("retry_busy", int'(bus.busy), 1);
    check("retry_done", int'(bus.done), 0);
    check("retry_attempts", int'(bus.attempts), att);
    check("retry_result_clr", int'(bus.result), 0);
    @(negedge Clock);
    bus.Go = 1'b0;
  endtask
`endif

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int m, t, x, y, z;
    exp_t e;
    bus.Go = 1'b0;
    bus.startEq = 1'b0;
    bus.mode = 2'd0;
    bus.OngoingTimer = '0;
    bus.DataIn = '0;

    do_reset();
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_correct", int'(bus.correct), 0);
    check("rst_div_err", int'(bus.div_err), 0);
    check("rst_result", int'(bus.result), 0);
    check("rst_attempts", int'(bus.attempts), 0);

    // mode 0: (6/2)^2 + 6/2 = 12 against timer 12
    start_round(0, 12);
    eval(0, 12, 6, 6, 2, 0, 0);
    end_round();

    // mode 1 wraps: 400 mod 256 = 144, no divide so no div_err
    start_round(1, 16);
    eval(1, 16, 20, 20, 0, 0, 0);
`ifdef EQ_RETRY_EN
    for (int k = 1; k <= 16; k++) begin
      retry_press((k < 15) ? k : 15);
      eval(1, 16, 20, 20, 0, (k < 15) ? k : 15, 0);
    end
    retry_press(15);
    eval(1, 16, 4, 4, 0, 15, 0);  // 16 == target: correct, attempts unchanged
    go_in_result(15);             // correct answer: Go does nothing
    end_round();                  // CLEAR zeroes attempts
`else
    go_in_result(0);
    end_round();
`endif

    // mode 2 divide by zero: 255, div_err, never correct even at timer 127
    start_round(2, 127);
    eval(2, 127, 5, 3, 0, 0, 0);
    end_round();

    // Go held 10 cycles on X with DataIn changing: only the first value counts
    start_round(1, 40);
    eval(1, 40, 7, 5, 5, 0, 9);
    end_round();

    // Abort in WAIT_Y
    start_round(1, 5);
    press(8'd9, 0);
    @(negedge Clock);
    bus.DataIn = 8'd3;
    bus.Go = 1'b1;
    @(negedge Clock);
    bus.startEq = 1'b0;
    bus.Go = 1'b0;
    @(posedge Clock);
    #1;
    check("abort_clear_busy", int'(bus.busy), 1);
    check("abort_clear_done", int'(bus.done), 0);
    @(posedge Clock);
    #1;
    check("abort_idle_busy", int'(bus.busy), 0);
    check("abort_idle_done", int'(bus.done), 0);
    check("abort_result", int'(bus.result), 0);
    check("abort_div_err", int'(bus.div_err), 0);

    // Reset in CALC2 goes straight to IDLE
    start_round(2, 10);
    press(8'd5, 0);
    press(8'd3, 0);
    press(8'd0, 0);
    @(posedge Clock);  // -> CALC0 (div by zero not until CALC3)
    @(posedge Clock);  // -> CALC1
    @(posedge Clock);  // -> CALC2
    @(negedge Clock);
    Reset = 1'b1;
    bus.startEq = 1'b0;
    @(posedge Clock);
    #1;
    check("rst_calc2_busy", int'(bus.busy), 0);
    check("rst_calc2_done", int'(bus.done), 0);
    check("rst_calc2_result", int'(bus.result), 0);
    @(negedge Clock);
    Reset = 1'b0;

    // Random rounds; half steer the timer to the true answer when it fits
    for (int i = 0; i < 24; i++) begin
      m = int'($urandom_range(0, 3));
      x = int'($urandom_range(0, 255));
      y = int'($urandom_range(0, 255));
      z = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
      if ($urandom_range(0, 1) == 1) z = int'($urandom_range(0, 7));
      t = int'($urandom_range(0, 127));
      e = model(m, t, x, y, z, 0);
      if ($urandom_range(0, 1) == 1 && e.result < 8'd128) t = int'(e.result);
      start_round(m, t);
      eval(m, t, x, y, z, 0, 0);
      end_round();
    end

    repeat (3) @(posedge Clock);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
